// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-128 types, S-box and round-constant tables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry r holds the constant used to derive round key r+1.
  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_sched_step.sv
// ============================================================================
// Module   : key_sched_step
// Purpose  : Combinational AES-128 key expansion step, rk[r] -> rk[r+1].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sched_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] rk_o
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_w4;
  logic [31:0] w_w5;
  logic [31:0] w_w6;
  logic [31:0] w_w7;

  assign w_rot = {rk_i[23:0], rk_i[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};

  assign w_w4 = rk_i[127:96] ^ w_sub ^ {rcon_i, 24'h000000};
  assign w_w5 = rk_i[95:64]  ^ w_w4;
  assign w_w6 = rk_i[63:32]  ^ w_w5;
  assign w_w7 = rk_i[31:0]   ^ w_w6;

  assign rk_o = {w_w4, w_w5, w_w6, w_w7};

endmodule

`default_nettype wire

// File: rtl/add_rkey_enc.sv
// ============================================================================
// Module   : add_rkey_enc
// Purpose  : AES-128 AddRoundKey stage with on-the-fly key schedule and a
//            valid/ready output register. Option: ADD_RKEY_ZEROIZE_EN clears
//            the keys after every block's final round.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_rkey_enc
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_i,
  input  logic         key_load_i,
  output logic         key_busy_o,
  input  logic [127:0] state_i,
  input  logic         state_valid_i,
  output logic         state_ready_o,
  output logic [127:0] state_o,
  output logic         state_valid_o,
  input  logic         state_ready_i,
  output logic [3:0]   round_o,
  output logic         last_o
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic [127:0] r_key;
  logic [127:0] r_wkey;
  logic [3:0]   r_round;
  logic [127:0] r_state;
  logic         r_valid;
  logic         r_last;

  logic         w_accept;
  logic         w_final;
  logic [7:0]   w_rcon;
  logic [127:0] w_rk_next;

  assign state_ready_o = !r_valid || state_ready_i;
  assign w_accept      = state_valid_i && state_ready_o;
  assign w_final       = (r_round == LAST_ROUND);

  always_comb begin
    w_rcon = 8'h00;
    if (r_round < LAST_ROUND) begin
      w_rcon = RCON[r_round];
    end
  end

  key_sched_step u_step (
    .rk_i   (r_wkey),
    .rcon_i (w_rcon),
    .rk_o   (w_rk_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_wkey  <= '0;
      r_round <= '0;
      r_state <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state <= state_i ^ r_wkey;
        r_valid <= 1'b1;
        r_last  <= w_final;
      end else if (state_ready_i) begin
        r_valid <= 1'b0;
      end

      if (w_accept) begin
        if (w_final) begin
          r_round <= '0;
`ifdef ADD_RKEY_ZEROIZE_EN
          r_key   <= '0;
          r_wkey  <= '0;
`else
          r_wkey  <= r_key;
`endif
        end else begin
          r_round <= r_round + 4'd1;
          r_wkey  <= w_rk_next;
        end
      end

      // A load racing a round-0 accept only replaces the stored key; the
      // working key keeps advancing through the block already in flight.
      if (key_load_i && (r_round == 4'd0)) begin
        r_key <= key_i;
        if (!w_accept) begin
          r_wkey <= key_i;
        end
      end
    end
  end

  assign state_o       = r_state;
  assign state_valid_o = r_valid;
  assign last_o        = r_last;
  assign round_o       = r_round;
  assign key_busy_o    = (r_round != 4'd0);

endmodule

`default_nettype wire
